// File: rtl/keypad_entry_scanner_if.sv
// Entry-side bundle of the keypad scanner: debounced key status plus the
// hex entry register handed to the seven-segment controller.
interface keypad_entry_scanner_if #(
  parameter int DIGITS = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic                  PRESSED;
  logic                  KEY_VALID;
  logic [3:0]            KEY_CODE;
  logic [4*DIGITS-1:0]   VALUE;
  logic [CW-1:0]         DIGIT_COUNT;
  logic                  FULL;

  modport master (
    output PRESSED, KEY_VALID, KEY_CODE, VALUE, DIGIT_COUNT, FULL
  );

  modport slave (
    input PRESSED, KEY_VALID, KEY_CODE, VALUE, DIGIT_COUNT, FULL
  );
endinterface

// File: rtl/keypad_entry_scanner.sv
// Matrix keypad front end: column scan on a prescaled tick, counted
// debounce of press and release, one strobe per accepted key and a
// DIGITS-wide hex entry register with optional backspace/clear keys.
module keypad_entry_scanner #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 131072,
  parameter int DEB_N     = 4,
  parameter int EDIT_KEYS = 0,
  parameter int SATURATE  = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [ROWS-1:0]        KEYPAD_ROWS,
  output logic [COLS-1:0]        KEYPAD_COLS,
  keypad_entry_scanner_if.master entry
);

  localparam int VW  = 4 * DIGITS;
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW  = $clog2(SCAN_DIV);
  localparam int DW  = $clog2(DEB_N + 1);

  if (ROWS * COLS > 16) begin : g_size_check
    $error("keypad_entry_scanner: ROWS*COLS must not exceed 16");
  end

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_DEB_P  = 2'd1,
    ST_ACCEPT = 2'd2,
    ST_HELD   = 2'd3
  } state_t;

  // Active-low one-hot column drive for a column index.
  function automatic logic [COLS-1:0] col_drive(input logic [CLW-1:0] col);
    col_drive = ~(COLS'(1'b1) << col);
  endfunction

  logic [ROWS-1:0] rows_meta_r, rows_sync_r;
  logic [PW-1:0]   presc_r;
  state_t          state_r, state_next;
  logic [CLW-1:0]  col_r, col_next;
  logic [RW-1:0]   row_r, row_next;
  logic [DW-1:0]   cnt_r, cnt_next;
  logic [COLS-1:0] cols_r;
  logic            pressed_r, pressed_next;
  logic            key_valid_r, key_valid_next;
  logic [3:0]      key_code_r, key_code_next;
  logic [VW-1:0]   value_r, value_next;
  logic [CW-1:0]   count_r, count_next;
  logic            full_r;

  logic            tick_s;
  logic [ROWS-1:0] row_low_s;
  logic            any_low_s;
  logic [RW-1:0]   row_first_s;
  logic            latched_low_s;
  logic [CLW-1:0]  col_inc_s;
  logic [3:0]      code_s;
  logic            full_s;
  logic            is_bs_s;
  logic            is_clr_s;

  // Two-flop synchroniser for the asynchronous row inputs (idle = pulled high).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rows_meta_r <= {ROWS{1'b1}};
      rows_sync_r <= {ROWS{1'b1}};
    end else begin
      rows_meta_r <= KEYPAD_ROWS;
      rows_sync_r <= rows_meta_r;
    end
  end

  assign tick_s = (presc_r == PW'(SCAN_DIV - 1));

  // Scan prescaler: free-running 0..SCAN_DIV-1, tick on the last count.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1'b1);
    end
  end

  assign row_low_s     = ~rows_sync_r;
  assign any_low_s     = |row_low_s;
  assign latched_low_s = row_low_s[row_r];
  assign col_inc_s     = (col_r == CLW'(COLS - 1)) ? {CLW{1'b0}} : col_r + CLW'(1'b1);
  assign code_s        = 4'(int'(row_r) * COLS + int'(col_r));
  assign full_s        = (count_r == CW'(DIGITS));
  assign is_bs_s       = (EDIT_KEYS != 0) && (code_s == 4'hE);
  assign is_clr_s      = (EDIT_KEYS != 0) && (code_s == 4'hF);

  // Lowest-index active row wins when several rows read low.
  always_comb begin
    row_first_s = {RW{1'b0}};
    for (int i = ROWS - 1; i >= 0; i--) begin
      row_first_s = row_low_s[i] ? RW'(i) : row_first_s;
    end
  end

  // Next-state logic: scan, debounce press, accept + entry edit, debounce release.
  always_comb begin
    state_next     = state_r;
    col_next       = col_r;
    row_next       = row_r;
    cnt_next       = cnt_r;
    pressed_next   = pressed_r;
    key_valid_next = 1'b0;
    key_code_next  = key_code_r;
    value_next     = value_r;
    count_next     = count_r;
    case (state_r)
      ST_SCAN: begin
        if (tick_s && any_low_s) begin
          row_next = row_first_s;
          if (DEB_N == 1) begin
            cnt_next   = {DW{1'b0}};
            state_next = ST_ACCEPT;
          end else begin
            cnt_next   = DW'(1'b1);
            state_next = ST_DEB_P;
          end
        end else if (tick_s) begin
          col_next = col_inc_s;
        end else begin
          state_next = ST_SCAN;
        end
      end
      ST_DEB_P: begin
        if (tick_s && latched_low_s) begin
          if (cnt_r == DW'(DEB_N - 1)) begin
            cnt_next   = {DW{1'b0}};
            state_next = ST_ACCEPT;
          end else begin
            cnt_next = cnt_r + DW'(1'b1);
          end
        end else if (tick_s) begin
          // Bounce: drop back to scanning the same column without a strobe.
          cnt_next   = {DW{1'b0}};
          state_next = ST_SCAN;
        end else begin
          state_next = ST_DEB_P;
        end
      end
      ST_ACCEPT: begin
        key_code_next  = code_s;
        key_valid_next = 1'b1;
        pressed_next   = 1'b1;
        cnt_next       = {DW{1'b0}};
        state_next     = ST_HELD;
        if (is_clr_s) begin
          value_next = {VW{1'b0}};
          count_next = {CW{1'b0}};
        end else if (is_bs_s) begin
          if (count_r != {CW{1'b0}}) begin
            value_next = value_r >> 3'd4;
            count_next = count_r - CW'(1'b1);
          end else begin
            value_next = value_r;
          end
        end else if (full_s && (SATURATE != 0)) begin
          value_next = value_r;
        end else begin
          value_next = (value_r << 3'd4) | VW'(code_s);
          count_next = full_s ? count_r : count_r + CW'(1'b1);
        end
      end
      ST_HELD: begin
        // Only the latched key is watched; other keys are ignored until release.
        if (tick_s && !latched_low_s) begin
          if (cnt_r == DW'(DEB_N - 1)) begin
            cnt_next     = {DW{1'b0}};
            pressed_next = 1'b0;
            col_next     = col_inc_s;
            state_next   = ST_SCAN;
          end else begin
            cnt_next = cnt_r + DW'(1'b1);
          end
        end else if (tick_s) begin
          cnt_next = {DW{1'b0}};
        end else begin
          state_next = ST_HELD;
        end
      end
      default: begin
        state_next = ST_SCAN;
        col_next   = {CLW{1'b0}};
        cnt_next   = {DW{1'b0}};
      end
    endcase
  end

  // State and output registers; column drive is registered from the next column.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r     <= ST_SCAN;
      col_r       <= {CLW{1'b0}};
      row_r       <= {RW{1'b0}};
      cnt_r       <= {DW{1'b0}};
      cols_r      <= col_drive({CLW{1'b0}});
      pressed_r   <= 1'b0;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      value_r     <= {VW{1'b0}};
      count_r     <= {CW{1'b0}};
      full_r      <= 1'b0;
    end else begin
      state_r     <= state_next;
      col_r       <= col_next;
      row_r       <= row_next;
      cnt_r       <= cnt_next;
      cols_r      <= col_drive(col_next);
      pressed_r   <= pressed_next;
      key_valid_r <= key_valid_next;
      key_code_r  <= key_code_next;
      value_r     <= value_next;
      count_r     <= count_next;
      full_r      <= (count_next == CW'(DIGITS));
    end
  end

  assign KEYPAD_COLS       = cols_r;
  assign entry.PRESSED     = pressed_r;
  assign entry.KEY_VALID   = key_valid_r;
  assign entry.KEY_CODE    = key_code_r;
  assign entry.VALUE       = value_r;
  assign entry.DIGIT_COUNT = count_r;
  assign entry.FULL        = full_r;

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Bench for keypad_entry_scanner: two instances (plain digits/rolling and
// edit keys/saturating) share one simulated keypad; a scoreboard queue per
// instance holds the expected result of every press.
module tb_keypad_entry_scanner;
  localparam int SD = 4;
  localparam int DN = 3;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] value;
    logic [2:0]  count;
    logic        full;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rows_a, rows_b, cols_a, cols_b;
  logic       key_on = 1'b0;
  int         key_row = 0;
  int         key_col = 0;

  int n_cmp = 0;
  int n_err = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t cur_a, cur_b;
  logic pend_a = 1'b0;
  logic pend_b = 1'b0;
  int   pushes_a = 0, pushes_b = 0, strobes_a = 0, strobes_b = 0;

  logic [15:0] m_val_a = 16'h0, m_val_b = 16'h0;
  logic [2:0]  m_cnt_a = 3'd0, m_cnt_b = 3'd0;

  keypad_entry_scanner_if #(.DIGITS(4)) ifc_a ();
  keypad_entry_scanner_if #(.DIGITS(4)) ifc_b ();

  keypad_entry_scanner #(.ROWS(4), .COLS(4), .DIGITS(4), .SCAN_DIV(SD), .DEB_N(DN),
                         .EDIT_KEYS(0), .SATURATE(0)) dut_a (
    .CLK(clk), .RESET(rst_n), .KEYPAD_ROWS(rows_a), .KEYPAD_COLS(cols_a), .entry(ifc_a));

  keypad_entry_scanner #(.ROWS(4), .COLS(4), .DIGITS(4), .SCAN_DIV(SD), .DEB_N(DN),
                         .EDIT_KEYS(1), .SATURATE(1)) dut_b (
    .CLK(clk), .RESET(rst_n), .KEYPAD_ROWS(rows_b), .KEYPAD_COLS(cols_b), .entry(ifc_b));

  always #5 clk = ~clk;

  // Keypad model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows_a = 4'b1111;
    rows_b = 4'b1111;
    if (key_on && !cols_a[key_col]) rows_a[key_row] = 1'b0;
    if (key_on && !cols_b[key_col]) rows_b[key_row] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit edit, input bit sat, input logic [3:0] k,
                            inout logic [15:0] v, inout logic [2:0] c);
    if (edit && k == 4'hE) begin
      if (c != 3'd0) begin
        v = v >> 4;
        c = c - 3'd1;
      end
    end else if (edit && k == 4'hF) begin
      v = 16'h0;
      c = 3'd0;
    end else if (!(sat && c == 3'd4)) begin
      v = {v[11:0], k};
      if (c < 3'd4) c = c + 3'd1;
    end
  endtask

  task automatic expect_key(input logic [3:0] k);
    exp_t e;
    model_step(1'b0, 1'b0, k, m_val_a, m_cnt_a);
    e = '{code: k, value: m_val_a, count: m_cnt_a, full: (m_cnt_a == 3'd4)};
    q_a.push_back(e);
    pushes_a++;
    model_step(1'b1, 1'b1, k, m_val_b, m_cnt_b);
    e = '{code: k, value: m_val_b, count: m_cnt_b, full: (m_cnt_b == 3'd4)};
    q_b.push_back(e);
    pushes_b++;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_cols_a"}, cols_a, 4'b1110);
    check_eq({tag, "_cols_b"}, cols_b, 4'b1110);
    check_eq({tag, "_pressed_a"}, ifc_a.PRESSED, 1'b0);
    check_eq({tag, "_kv_a"}, ifc_a.KEY_VALID, 1'b0);
    check_eq({tag, "_code_a"}, ifc_a.KEY_CODE, 4'h0);
    check_eq({tag, "_value_a"}, ifc_a.VALUE, 16'h0);
    check_eq({tag, "_value_b"}, ifc_b.VALUE, 16'h0);
    check_eq({tag, "_count_a"}, ifc_a.DIGIT_COUNT, 3'd0);
    check_eq({tag, "_count_b"}, ifc_b.DIGIT_COUNT, 3'd0);
    check_eq({tag, "_full_b"}, ifc_b.FULL, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    m_val_a = 16'h0; m_cnt_a = 3'd0; m_val_b = 16'h0; m_cnt_b = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns on the first negedge after column c becomes the driven one.
  task automatic wait_col(input int c);
    int n = 0;
    @(negedge clk);
    while (cols_a[c] !== 1'b1 && n < 16 * SD) begin @(negedge clk); n++; end
    while (cols_a[c] !== 1'b0 && n < 32 * SD) begin @(negedge clk); n++; end
    check_eq("wait_col", cols_a[c], 1'b0);
  endtask

  task automatic press_start(input logic [3:0] k);
    int n = 0;
    expect_key(k);
    key_row = int'(k) / 4;
    key_col = int'(k) % 4;
    wait_col(key_col);
    key_on = 1'b1;
    while (!ifc_a.PRESSED && n < 8 * SD) begin @(negedge clk); n++; end
    check_eq("press_a", ifc_a.PRESSED, 1'b1);
    check_eq("press_b", ifc_b.PRESSED, 1'b1);
  endtask

  task automatic release_key();
    @(negedge clk);
    key_on = 1'b0;
    repeat (2 * SD) @(negedge clk);
    check_eq("rel_early_a", ifc_a.PRESSED, 1'b1);
    repeat (3 * SD) @(negedge clk);
    check_eq("rel_done_a", ifc_a.PRESSED, 1'b0);
    check_eq("rel_done_b", ifc_b.PRESSED, 1'b0);
    repeat (SD) @(negedge clk);
  endtask

  task automatic tap(input logic [3:0] k, input int hold);
    press_start(k);
    repeat (hold) @(negedge clk);
    release_key();
  endtask

  // Scoreboard for instance A: pop on strobe, check the entry register a cycle later.
  always @(negedge clk) begin
    if (pend_a) begin
      check_eq("value_a", ifc_a.VALUE, cur_a.value);
      check_eq("count_a", ifc_a.DIGIT_COUNT, cur_a.count);
      check_eq("full_a", ifc_a.FULL, cur_a.full);
      pend_a = 1'b0;
    end
    if (rst_n && ifc_a.KEY_VALID) begin
      strobes_a++;
      if (q_a.size() == 0) begin
        check_eq("spurious_kv_a", ifc_a.KEY_VALID, 1'b0);
      end else begin
        cur_a = q_a.pop_front();
        check_eq("code_a", ifc_a.KEY_CODE, cur_a.code);
        pend_a = 1'b1;
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (pend_b) begin
      check_eq("value_b", ifc_b.VALUE, cur_b.value);
      check_eq("count_b", ifc_b.DIGIT_COUNT, cur_b.count);
      check_eq("full_b", ifc_b.FULL, cur_b.full);
      pend_b = 1'b0;
    end
    if (rst_n && ifc_b.KEY_VALID) begin
      strobes_b++;
      if (q_b.size() == 0) begin
        check_eq("spurious_kv_b", ifc_b.KEY_VALID, 1'b0);
      end else begin
        cur_b = q_b.pop_front();
        check_eq("code_b", ifc_b.KEY_CODE, cur_b.code);
        pend_b = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] e_cols;

    // Power-on reset state.
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;

    // Idle scan: each column held for SD cycles, wrapping after the last.
    n = 0;
    while (cols_a !== 4'b1101 && n < 8 * SD) begin @(negedge clk); n++; end
    check_eq("scan_start", cols_a, 4'b1101);
    for (int i = 0; i < 4 * SD; i++) begin
      e_cols = ~(4'b0001 << ((1 + i / SD) % 4));
      check_eq("scan_a", cols_a, e_cols);
      check_eq("scan_b", cols_b, e_cols);
      @(negedge clk);
    end

    // Key row1/col2 held for 50 ticks: exactly one strobe, code 6.
    tap(4'h6, 50 * SD);
    check_eq("k6_value_a", ifc_a.VALUE, 16'h0006);
    check_eq("k6_count_a", ifc_a.DIGIT_COUNT, 3'd1);

    // Bounce: exactly two low samples, then high.
    key_row = 1;
    key_col = 2;
    wait_col(2);
    key_on = 1'b1;
    repeat (2 * SD) @(negedge clk);
    key_on = 1'b0;
    repeat (10 * SD) @(negedge clk);
    check_eq("bounce_pressed_a", ifc_a.PRESSED, 1'b0);
    check_eq("bounce_value_a", ifc_a.VALUE, 16'h0006);
    check_eq("bounce_count_a", ifc_a.DIGIT_COUNT, 3'd1);

    // Overflow: rolling vs saturating entry.
    do_reset();
    for (int d = 1; d <= 5; d++) tap(4'(d), 2 * SD);
    check_eq("ovf_value_a", ifc_a.VALUE, 16'h2345);
    check_eq("ovf_full_a", ifc_a.FULL, 1'b1);
    check_eq("ovf_value_b", ifc_b.VALUE, 16'h1234);
    check_eq("ovf_full_b", ifc_b.FULL, 1'b1);

    // Reset while a key is held, then re-detection of the same held key.
    press_start(4'h6);
    repeat (5 * SD) @(negedge clk);
    check_eq("held_value_b", ifc_b.VALUE, 16'h1234);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_state("mid_held");
    m_val_a = 16'h0; m_cnt_a = 3'd0; m_val_b = 16'h0; m_cnt_b = 3'd0;
    repeat (3) @(negedge clk);
    expect_key(4'h6);
    rst_n = 1'b1;
    n = 0;
    while (!ifc_a.PRESSED && n < 16 * SD) begin @(negedge clk); n++; end
    check_eq("redetect_a", ifc_a.PRESSED, 1'b1);
    release_key();
    check_eq("redetect_value_a", ifc_a.VALUE, 16'h0006);

    // Edit keys on instance B; instance A treats 0xE/0xF as digits.
    do_reset();
    tap(4'h7, 2 * SD);
    tap(4'h8, 2 * SD);
    tap(4'hE, 2 * SD);
    check_eq("bs_value_b", ifc_b.VALUE, 16'h0007);
    check_eq("bs_count_b", ifc_b.DIGIT_COUNT, 3'd1);
    tap(4'hF, 2 * SD);
    check_eq("clr_value_b", ifc_b.VALUE, 16'h0000);
    tap(4'hE, 2 * SD);
    check_eq("bs_empty_value_b", ifc_b.VALUE, 16'h0000);
    check_eq("bs_empty_count_b", ifc_b.DIGIT_COUNT, 3'd0);
    check_eq("digits_value_a", ifc_a.VALUE, 16'h8EFE);

    // Every expected strobe arrived and no extra one did.
    repeat (4) @(negedge clk);
    check_eq("strobes_a", strobes_a, pushes_a);
    check_eq("strobes_b", strobes_b, pushes_b);
    check_eq("queue_a_left", q_a.size(), 0);
    check_eq("queue_b_left", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
